// File: rtl/bus_arbiter.sv
// Time-slices the shared RAM/IO bus: phi2-low half serves at most one Pi request,
// phi2-high half always belongs to the 6502. All outputs are registered.
module bus_arbiter #(
  parameter int HALF_CLKS = 8
) (
  input  logic                             sys_clk,
  input  logic                             reset_n,
  input  logic                             pi_pending,
  input  logic                             pi_rw_b,
  output logic                             pi_done,
  output logic                             pi_grant,
  output logic                             pi_data_strobe,
  input  logic                             cpu_rw_b,
  output logic                             phi2,
  output logic                             cpu_be,
  output logic                             ram_oe_n,
  output logic                             ram_we_n,
  output logic [$clog2(2*HALF_CLKS)-1:0]   cycle_pos
);

  localparam int CW = $clog2(2*HALF_CLKS);
  localparam logic [CW-1:0] LAST = CW'(2*HALF_CLKS-1);
  localparam logic [CW-1:0] HALF = CW'(HALF_CLKS);

  typedef enum logic [1:0] {PI_IDLE, PI_BUSY, PI_ACK} pi_state_e;

  pi_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, p;
  logic            pi_rw_q, pi_rw_d, cpu_rw_q, cpu_rw_d;
  logic            done_q, done_d, grant_q, grant_d, strobe_q, strobe_d;
  logic            phi2_q, phi2_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic            in_pi, accept, busy_now, rd_win, wr_win, cpu_rd, cpu_wr, pi_rd, pi_wr;

  always_comb begin
    in_pi    = cnt_q < HALF;
    p        = in_pi ? cnt_q : cnt_q - HALF;
    rd_win   = (p >= CW'(1)) && (p <= CW'(HALF_CLKS-2));
    wr_win   = (p >= CW'(2)) && (p <= CW'(HALF_CLKS-3));
    accept   = (cnt_q == '0) && (state_q == PI_IDLE) && pi_pending && !done_q;
    busy_now = accept || (state_q == PI_BUSY);

    cnt_d    = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    state_d  = state_q;
    pi_rw_d  = pi_rw_q;
    cpu_rw_d = cpu_rw_q;
    done_d   = done_q;

    case (state_q)
      PI_IDLE: if (accept) begin
        state_d = PI_BUSY;
        pi_rw_d = pi_rw_b;
      end
      PI_BUSY: if (cnt_q == CW'(HALF_CLKS-2)) begin
        state_d = PI_ACK;
        done_d  = 1'b1;
      end
      PI_ACK: if (!pi_pending) begin
        state_d = PI_IDLE;
        done_d  = 1'b0;
      end
      default: state_d = PI_IDLE;
    endcase

    if (cnt_q == HALF) cpu_rw_d = cpu_rw_b;

    // Grant is held from slot start to slot end even after the FSM moves to PI_ACK.
    grant_d  = in_pi && (busy_now || grant_q);
    phi2_d   = !in_pi;
    cpu_rd   = !in_pi && cpu_rw_q && rd_win;
    cpu_wr   = !in_pi && !cpu_rw_q && wr_win;
    pi_rd    = in_pi && (state_q == PI_BUSY) && pi_rw_q && rd_win;
    pi_wr    = in_pi && (state_q == PI_BUSY) && !pi_rw_q && wr_win;
    oe_n_d   = !(cpu_rd || pi_rd);
    we_n_d   = !(cpu_wr || pi_wr);
    strobe_d = in_pi && (state_q == PI_BUSY) && pi_rw_q && (p == CW'(HALF_CLKS-3));
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      state_q  <= PI_IDLE;
      pi_rw_q  <= 1'b1;
      cpu_rw_q <= 1'b1;
      done_q   <= 1'b0;
      grant_q  <= 1'b0;
      strobe_q <= 1'b0;
      phi2_q   <= 1'b0;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      pi_rw_q  <= pi_rw_d;
      cpu_rw_q <= cpu_rw_d;
      done_q   <= done_d;
      grant_q  <= grant_d;
      strobe_q <= strobe_d;
      phi2_q   <= phi2_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
    end
  end

  assign pi_done        = done_q;
  assign pi_grant       = grant_q;
  assign pi_data_strobe = strobe_q;
  assign phi2           = phi2_q;
  assign cpu_be         = phi2_q;
  assign ram_oe_n       = oe_n_q;
  assign ram_we_n       = we_n_q;
  assign cycle_pos      = cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed test-plan steps followed by random traffic, all
// checked against a timeline model of slots and Pi accesses.
module tb_bus_arbiter;
  localparam int H  = 8;
  localparam int P  = 2*H;
  localparam int CW = $clog2(P);

  logic          sys_clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          pi_pending = 1'b0;
  logic          pi_rw_b = 1'b1;
  logic          cpu_rw_b = 1'b1;
  logic          pi_done, pi_grant, pi_data_strobe, phi2, cpu_be, ram_oe_n, ram_we_n;
  logic [CW-1:0] cycle_pos;

  int errors = 0;
  int checks = 0;

  // Model: n = index of the next clock edge since reset release; one access record.
  int n;
  bit acc_valid;
  int acc_start;
  bit acc_rw;
  int clr_edge;
  bit cpu_rw_m;

  bus_arbiter #(.HALF_CLKS(H)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .pi_pending(pi_pending), .pi_rw_b(pi_rw_b), .pi_done(pi_done),
    .pi_grant(pi_grant), .pi_data_strobe(pi_data_strobe),
    .cpu_rw_b(cpu_rw_b), .phi2(phi2), .cpu_be(cpu_be),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .cycle_pos(cycle_pos)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    acc_valid = 1'b0;
    acc_start = 0;
    acc_rw = 1'b1;
    clr_edge = -1;
  endtask

  task automatic tick();
    int pos, p;
    bit pend, prw, crw, cpu, act, idle, rd_on, wr_on;
    bit e_oe_n, e_we_n, e_strb, e_done;
    @(posedge sys_clk);
    pend = pi_pending;
    prw  = pi_rw_b;
    crw  = cpu_rw_b;
    pos  = n % P;
    if (acc_valid && clr_edge < 0 && n >= acc_start + H - 1 && !pend) clr_edge = n;
    idle = !acc_valid || (clr_edge >= 0 && clr_edge < n);
    if (pos == 0 && pend && idle) begin
      acc_valid = 1'b1;
      acc_start = n;
      acc_rw    = prw;
      clr_edge  = -1;
    end
    if (pos == H) cpu_rw_m = crw;
    cpu   = pos >= H;
    p     = cpu ? pos - H : pos;
    act   = acc_valid && n >= acc_start && n <= acc_start + H - 1;
    rd_on = p >= 1 && p <= H - 2;
    wr_on = p >= 2 && p <= H - 3;
    e_oe_n = !((cpu && cpu_rw_m && rd_on) || (act && acc_rw && rd_on));
    e_we_n = !((cpu && !cpu_rw_m && wr_on) || (act && !acc_rw && wr_on));
    e_strb = act && acc_rw && p == H - 3;
    e_done = acc_valid && n >= acc_start + H - 2 && (clr_edge < 0 || n < clr_edge);
    #1;
    chk("cycle_pos", cycle_pos, (n + 1) % P);
    chk("phi2", phi2, cpu);
    chk("cpu_be", cpu_be, cpu);
    chk("pi_grant", pi_grant, act);
    chk("ram_oe_n", ram_oe_n, e_oe_n);
    chk("ram_we_n", ram_we_n, e_we_n);
    chk("pi_data_strobe", pi_data_strobe, e_strb);
    chk("pi_done", pi_done, e_done);
    chk("inv_oe_we", !(ram_oe_n == 1'b0 && ram_we_n == 1'b0), 1);
    chk("inv_grant_be", !(pi_grant && cpu_be), 1);
    n++;
  endtask

  task automatic run_to(input int pos);
    while ((n % P) != pos) tick();
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (pi_done !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
    chk("done_wait", pi_done, 1);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_phi2"}, phi2, 0);
    chk({tag, "_cpu_be"}, cpu_be, 0);
    chk({tag, "_grant"}, pi_grant, 0);
    chk({tag, "_strobe"}, pi_data_strobe, 0);
    chk({tag, "_done"}, pi_done, 0);
    chk({tag, "_oe_n"}, ram_oe_n, 1);
    chk({tag, "_we_n"}, ram_we_n, 1);
    chk({tag, "_pos"}, cycle_pos, 0);
  endtask

  initial begin
    int cnt, oe_low;
    bit prev;
    model_reset();
    cpu_rw_m = 1'b1;

    // Reset and idle bus
    #1 reset_n = 1'b0;
    #1 reset_outputs("reset");
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    reset_n = 1'b1;
    oe_low = 0;
    repeat (3*P) begin
      tick();
      if (ram_oe_n == 1'b0) oe_low++;
    end
    chk("idle_oe_low_clocks", oe_low, 3*(H-2));

    // Pi read raised at counter 3
    run_to(3);
    pi_pending = 1'b1;
    pi_rw_b    = 1'b1;
    wait_done(3*P);
    repeat (2) tick();
    pi_pending = 1'b0;
    repeat (4) tick();

    // Pi write with CPU writing too
    cpu_rw_b = 1'b0;
    run_to(10);
    pi_pending = 1'b1;
    pi_rw_b    = 1'b0;
    wait_done(3*P);
    pi_pending = 1'b0;
    repeat (P) tick();
    cpu_rw_b = 1'b1;

    // Held pending: one access only, then a second after re-raise
    pi_pending = 1'b1;
    pi_rw_b    = 1'b1;
    wait_done(3*P);
    cnt  = 0;
    prev = pi_grant;
    repeat (3*P) begin
      tick();
      if (pi_grant && !prev) cnt++;
      prev = pi_grant;
    end
    chk("held_no_regrant", cnt, 0);
    chk("held_done_high", pi_done, 1);
    pi_pending = 1'b0;
    repeat (2) tick();
    pi_pending = 1'b1;
    wait_done(3*P);
    pi_pending = 1'b0;
    repeat (4) tick();

    // Abandoned request: pending drops at p=2 of the access
    run_to(0);
    pi_pending = 1'b1;
    pi_rw_b    = 1'b1;
    tick();
    tick();
    pi_pending = 1'b0;
    cnt = 0;
    repeat (2*P) begin
      tick();
      if (pi_done) cnt++;
    end
    chk("abandon_done_clocks", cnt, 1);

    // Asynchronous reset in the middle of a Pi write
    run_to(0);
    pi_pending = 1'b1;
    pi_rw_b    = 1'b0;
    repeat (4) tick();
    chk("pre_reset_we_active", ram_we_n, 0);
    #2 reset_n = 1'b0;
    pi_pending = 1'b0;
    #1 reset_outputs("async");
    @(negedge sys_clk);
    reset_n = 1'b1;
    model_reset();
    cnt = 0;
    repeat (3*P) begin
      tick();
      if (pi_grant) cnt++;
    end
    chk("post_reset_no_grant", cnt, 0);

    // Random traffic
    repeat (1500) begin
      if ($urandom_range(0, 9) == 0) pi_pending = ~pi_pending;
      pi_rw_b  = 1'($urandom_range(0, 1));
      cpu_rw_b = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
